// File: rtl/note_pkg.sv
// -----------------------------------------------------------------------------
// note_pkg
// Shared definitions for the note lane scroller:
//   - two-bit chart note codes (bit0 red, bit1 blue)
//   - scroller state enumeration
//   - saturating add helper used by the statistics counters
// -----------------------------------------------------------------------------
package note_pkg;

  localparam logic [1:0] NOTE_NONE = 2'd0;
  localparam logic [1:0] NOTE_R    = 2'd1;
  localparam logic [1:0] NOTE_B    = 2'd2;
  localparam logic [1:0] NOTE_RB   = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Adds inc to value and clamps the result at max_value. Operands are
  // 32-bit so one function serves every counter width; callers cast.
  function automatic logic [31:0] sat_add(input logic [31:0] value,
                                          input logic [31:0] inc,
                                          input logic [31:0] max_value);
    logic [32:0] sum;
    sum = {1'b0, value} + {1'b0, inc};
    if (sum > {1'b0, max_value}) begin
      return max_value;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/note_judge.sv
// -----------------------------------------------------------------------------
// note_judge
// Hit/miss evaluation and statistics for one note lane.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             clears combo, max_combo and miss_cnt (new song)
//   hit_en            hits are judged only while high
//   hit_r, hit_b      one-cycle button press pulses
//   shift             window shifts this cycle (cell_low is discarded)
//   cell_hit          current code of the judged cell
//   cell_low          current code of cell 0
//   clr_r, clr_b      accepted hits; the window clears these bits
//   combo, max_combo, miss_cnt  saturating statistics
// -----------------------------------------------------------------------------
module note_judge
  import note_pkg::*;
#(
  parameter int COMBO_W = 8,
  parameter int STRICT  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               hit_en,
  input  logic               hit_r,
  input  logic               hit_b,
  input  logic               shift,
  input  logic [1:0]         cell_hit,
  input  logic [1:0]         cell_low,
  output logic               clr_r,
  output logic               clr_b,
  output logic [COMBO_W-1:0] combo,
  output logic [COMBO_W-1:0] max_combo,
  output logic [COMBO_W-1:0] miss_cnt
);

  localparam logic [COMBO_W-1:0] SAT_MAX = '1;

  logic               bad_r, bad_b, miss;
  logic [1:0]         hit_inc;
  logic [COMBO_W-1:0] combo_nxt, max_nxt, miss_nxt;

  assign clr_r   = hit_en && hit_r && ((cell_hit & NOTE_R) != NOTE_NONE);
  assign clr_b   = hit_en && hit_b && ((cell_hit & NOTE_B) != NOTE_NONE);
  assign bad_r   = hit_en && hit_r && ((cell_hit & NOTE_R) == NOTE_NONE);
  assign bad_b   = hit_en && hit_b && ((cell_hit & NOTE_B) == NOTE_NONE);
  assign miss    = shift && (cell_low != NOTE_NONE);
  assign hit_inc = {1'b0, clr_r} + {1'b0, clr_b};

  // Order of effects within one cycle: a miss (or a strict wrong press)
  // zeroes the combo first, then accepted hits add on top.
  // NOTE: every variable written in always_comb gets a default on entry so no
  // path leaves it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    combo_nxt = combo;
    miss_nxt  = miss_cnt;
    if (miss) begin
      combo_nxt = '0;
      miss_nxt  = COMBO_W'(sat_add(32'(miss_cnt), 32'd1, 32'(SAT_MAX)));
    end
    if ((STRICT != 0) && (bad_r || bad_b)) begin
      combo_nxt = '0;
    end
    combo_nxt = COMBO_W'(sat_add(32'(combo_nxt), 32'(hit_inc), 32'(SAT_MAX)));
    max_nxt   = (combo_nxt > max_combo) ? combo_nxt : max_combo;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      combo     <= '0;
      max_combo <= '0;
      miss_cnt  <= '0;
    end else if (clear) begin
      combo     <= '0;
      max_combo <= '0;
      miss_cnt  <= '0;
    end else begin
      combo     <= combo_nxt;
      max_combo <= max_nxt;
      miss_cnt  <= miss_nxt;
    end
  end

endmodule

// File: rtl/note_lane_scroller.sv
// -----------------------------------------------------------------------------
// note_lane_scroller
// Scrolling note window for the LED-matrix rhythm game. Chart codes are read
// from an external ROM one cell at a time, scrolled down with SUBSTEPS pixel
// sub-offsets per cell, and judged at cell HIT_POS by note_judge.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    start song (IDLE) / acknowledge (DONE)
//   pause                    freezes scrolling and ignores hits
//   song_len, tick_period    song length and sub-step period-1, taken on start
//   chart_rd, chart_addr     ROM read request pulse and held address
//   chart_data, chart_vld    ROM response
//   hit_r, hit_b             button press pulses
//   note_r, note_b           per-cell colour bitmaps (cell 0 = bottom)
//   offset                   current sub-offset within a cell
//   judge_r, judge_b         colour bits at the judged cell
//   combo, max_combo, miss_cnt  statistics
//   busy, finish             song in progress / song complete
// -----------------------------------------------------------------------------
module note_lane_scroller
  import note_pkg::*;
#(
  parameter int LANE_DEPTH = 10,
  parameter int SUBSTEPS   = 7,
  parameter int HIT_POS    = 1,
  parameter int ADDR_W     = 10,
  parameter int TICK_W     = 17,
  parameter int COMBO_W    = 8,
  parameter int STRICT     = 0,
  localparam int OFF_W     = $clog2(SUBSTEPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pause,
  input  logic [ADDR_W-1:0]     song_len,
  input  logic [TICK_W-1:0]     tick_period,
  output logic                  chart_rd,
  output logic [ADDR_W-1:0]     chart_addr,
  input  logic [1:0]            chart_data,
  input  logic                  chart_vld,
  input  logic                  hit_r,
  input  logic                  hit_b,
  output logic [LANE_DEPTH-1:0] note_r,
  output logic [LANE_DEPTH-1:0] note_b,
  output logic [OFF_W-1:0]      offset,
  output logic                  judge_r,
  output logic                  judge_b,
  output logic [COMBO_W-1:0]    combo,
  output logic [COMBO_W-1:0]    max_combo,
  output logic [COMBO_W-1:0]    miss_cnt,
  output logic                  busy,
  output logic                  finish
);

  localparam int                 DRAIN_W    = $clog2(LANE_DEPTH + 1);
  localparam logic [OFF_W-1:0]   LAST_OFF   = OFF_W'(SUBSTEPS - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(LANE_DEPTH - 1);

  state_t                state;
  logic [LANE_DEPTH-1:0] win_r, win_b, kept_r, kept_b, win_r_nxt, win_b_nxt;
  logic [ADDR_W-1:0]     index, len_q;
  logic [TICK_W-1:0]     tick, period_q;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic                  launch, fetch_done, scrolling, cell_step, shift;
  logic                  hit_en, clr_r, clr_b;
  logic [1:0]            new_code;

  assign launch     = (state == IDLE) && start;
  // A valid in the request cycle itself can only be stale (ROM latency is at
  // least one cycle), so it is not taken as the answer.
  assign fetch_done = (state == FETCH) && chart_vld && !chart_rd;
  assign scrolling  = ((state == RUN) || (state == DRAIN)) && !pause;
  assign cell_step  = scrolling && (tick == period_q) && (offset == LAST_OFF);
  assign shift      = fetch_done || ((state == DRAIN) && cell_step);
  assign new_code   = (state == FETCH) ? (chart_data & NOTE_RB) : NOTE_NONE;

  assign busy    = (state == FETCH) || (state == RUN) || (state == DRAIN);
  assign finish  = (state == DONE);
  assign hit_en  = busy && !pause;

  assign note_r  = win_r;
  assign note_b  = win_b;
  assign judge_r = win_r[HIT_POS];
  assign judge_b = win_b[HIT_POS];

  note_judge #(
    .COMBO_W (COMBO_W),
    .STRICT  (STRICT)
  ) u_judge (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (launch),
    .hit_en    (hit_en),
    .hit_r     (hit_r),
    .hit_b     (hit_b),
    .shift     (shift),
    .cell_hit  ({win_b[HIT_POS], win_r[HIT_POS]}),
    .cell_low  ({win_b[0], win_r[0]}),
    .clr_r     (clr_r),
    .clr_b     (clr_b),
    .combo     (combo),
    .max_combo (max_combo),
    .miss_cnt  (miss_cnt)
  );

  // Hits are applied to the pre-shift window, so a note hit on the shifting
  // cycle arrives at HIT_POS-1 already cleared.
  always_comb begin
    kept_r    = win_r & ~(LANE_DEPTH'(clr_r) << HIT_POS);
    kept_b    = win_b & ~(LANE_DEPTH'(clr_b) << HIT_POS);
    win_r_nxt = kept_r;
    win_b_nxt = kept_b;
    if (shift) begin
      win_r_nxt = {new_code[0], kept_r[LANE_DEPTH-1:1]};
      win_b_nxt = {new_code[1], kept_b[LANE_DEPTH-1:1]};
    end
  end

  // NOTE: the window is only 2*LANE_DEPTH flops, not a RAM, so it takes the
  // asynchronous reset like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_r <= '0;
      win_b <= '0;
    end else if (launch) begin
      win_r <= '0;
      win_b <= '0;
    end else begin
      win_r <= win_r_nxt;
      win_b <= win_b_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      chart_rd   <= 1'b0;
      chart_addr <= '0;
      index      <= '0;
      len_q      <= '0;
      period_q   <= '0;
      tick       <= '0;
      offset     <= '0;
      drain_cnt  <= '0;
    end else begin
      chart_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q     <= song_len;
            period_q  <= tick_period;
            index     <= '0;
            tick      <= '0;
            offset    <= '0;
            drain_cnt <= '0;
            if (song_len == '0) begin
              state <= DRAIN;
            end else begin
              state      <= FETCH;
              chart_rd   <= 1'b1;
              chart_addr <= '0;
            end
          end
        end
        FETCH: begin
          if (fetch_done) begin
            index <= index + 1'b1;
            state <= RUN;
          end
        end
        RUN, DRAIN: begin
          if (scrolling) begin
            if (tick != period_q) begin
              tick <= tick + 1'b1;
            end else begin
              tick <= '0;
              if (offset != LAST_OFF) begin
                offset <= offset + 1'b1;
              end else begin
                offset <= '0;
                if (state == DRAIN) begin
                  drain_cnt <= drain_cnt + 1'b1;
                  if (drain_cnt == LAST_DRAIN) begin
                    state <= DONE;
                  end
                end else if (index < len_q) begin
                  state      <= FETCH;
                  chart_rd   <= 1'b1;
                  chart_addr <= index;
                end else begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
                end
              end
            end
          end
        end
        DONE: begin
          if (start) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_lane_scroller.sv
// -----------------------------------------------------------------------------
// tb_note_lane_scroller
// Drives two scroller instances (STRICT=0 and STRICT=1) with identical
// stimulus and compares them every cycle against a queue-based reference
// model of the lane: the window is a queue of codes, scroll timing is an
// elapsed-tick count per cell, statistics are plain clamped integers.
// -----------------------------------------------------------------------------
module tb_note_lane_scroller;

  localparam int LANE_DEPTH = 10;
  localparam int SUBSTEPS   = 7;
  localparam int HIT_POS    = 1;
  localparam int ADDR_W     = 10;
  localparam int TICK_W     = 17;
  localparam int COMBO_W    = 8;
  localparam int OFF_W      = $clog2(SUBSTEPS);
  localparam int CMAX       = (1 << COMBO_W) - 1;

  localparam int P_IDLE = 0, P_FETCH = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause = 1'b0;
  logic chart_vld = 1'b0, hit_r = 1'b0, hit_b = 1'b0;
  logic [ADDR_W-1:0] song_len = '0;
  logic [TICK_W-1:0] tick_period = '0;
  logic [1:0]        chart_data = '0;

  logic                  rd0, rd1, jr0, jb0, jr1, jb1, busy0, busy1, fin0, fin1;
  logic [ADDR_W-1:0]     addr0, addr1;
  logic [LANE_DEPTH-1:0] nr0, nb0, nr1, nb1;
  logic [OFF_W-1:0]      off0, off1;
  logic [COMBO_W-1:0]    combo0, max0, miss0, combo1, max1, miss1;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  note_lane_scroller #(.STRICT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .song_len(song_len), .tick_period(tick_period),
    .chart_rd(rd0), .chart_addr(addr0), .chart_data(chart_data), .chart_vld(chart_vld),
    .hit_r(hit_r), .hit_b(hit_b), .note_r(nr0), .note_b(nb0), .offset(off0),
    .judge_r(jr0), .judge_b(jb0), .combo(combo0), .max_combo(max0), .miss_cnt(miss0),
    .busy(busy0), .finish(fin0)
  );

  note_lane_scroller #(.STRICT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .song_len(song_len), .tick_period(tick_period),
    .chart_rd(rd1), .chart_addr(addr1), .chart_data(chart_data), .chart_vld(chart_vld),
    .hit_r(hit_r), .hit_b(hit_b), .note_r(nr1), .note_b(nb1), .offset(off1),
    .judge_r(jr1), .judge_b(jb1), .combo(combo1), .max_combo(max1), .miss_cnt(miss1),
    .busy(busy1), .finish(fin1)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_phase, m_ticks, m_idx, m_len, m_period, m_drained, m_addr, m_miss;
  bit m_rd;
  int m_cells[$];
  int m_combo[2], m_max[2];

  task automatic model_reset();
    m_phase = P_IDLE; m_ticks = 0; m_idx = 0; m_len = 0; m_period = 0;
    m_drained = 0; m_addr = 0; m_miss = 0; m_rd = 1'b0;
    m_cells.delete();
    for (int k = 0; k < LANE_DEPTH; k++) m_cells.push_back(0);
    m_combo = '{0, 0};
    m_max = '{0, 0};
  endtask

  // A cell lasts SUBSTEPS*(period+1) unpaused cycles of scrolling.
  function automatic bit m_cell_done();
    return (m_phase == P_RUN || m_phase == P_DRAIN) && !pause &&
           (m_ticks + 1 == SUBSTEPS * (m_period + 1));
  endfunction

  function automatic bit m_shift_now();
    return (m_phase == P_FETCH && chart_vld && !m_rd) ||
           (m_phase == P_DRAIN && m_cell_done());
  endfunction

  task automatic model_step();
    bit done_cell, shift, hits_on, good_r, good_b, bad_r, bad_b;
    int code, hc, inc;
    done_cell = m_cell_done();
    shift     = m_shift_now();
    code      = (m_phase == P_FETCH) ? int'(chart_data) : 0;
    hits_on   = (m_phase == P_FETCH || m_phase == P_RUN || m_phase == P_DRAIN) && !pause;
    if ((m_phase == P_RUN || m_phase == P_DRAIN) && !pause)
      m_ticks = done_cell ? 0 : m_ticks + 1;
    hc     = m_cells[HIT_POS];
    good_r = hits_on && hit_r && ((hc & 1) != 0);
    good_b = hits_on && hit_b && ((hc & 2) != 0);
    bad_r  = hits_on && hit_r && ((hc & 1) == 0);
    bad_b  = hits_on && hit_b && ((hc & 2) == 0);
    inc    = int'(good_r) + int'(good_b);
    if (shift && m_cells[0] != 0) begin
      m_miss  = (m_miss + 1 > CMAX) ? CMAX : m_miss + 1;
      m_combo = '{0, 0};
    end
    for (int d = 0; d < 2; d++) begin
      if (d == 1 && (bad_r || bad_b)) m_combo[d] = 0;
      m_combo[d] = (m_combo[d] + inc > CMAX) ? CMAX : m_combo[d] + inc;
      if (m_combo[d] > m_max[d]) m_max[d] = m_combo[d];
    end
    if (good_r) hc = hc & 2;
    if (good_b) hc = hc & 1;
    m_cells[HIT_POS] = hc;
    if (shift) begin
      void'(m_cells.pop_front());
      m_cells.push_back(code);
    end
    m_rd = 1'b0;
    case (m_phase)
      P_IDLE: if (start) begin
        for (int k = 0; k < LANE_DEPTH; k++) m_cells[k] = 0;
        m_combo = '{0, 0}; m_max = '{0, 0}; m_miss = 0;
        m_len = int'(song_len); m_period = int'(tick_period);
        m_idx = 0; m_ticks = 0; m_drained = 0;
        if (m_len == 0) m_phase = P_DRAIN;
        else begin m_phase = P_FETCH; m_rd = 1'b1; m_addr = 0; end
      end
      P_FETCH: if (shift) begin m_idx++; m_phase = P_RUN; end
      P_RUN: if (done_cell) begin
        if (m_idx < m_len) begin m_phase = P_FETCH; m_rd = 1'b1; m_addr = m_idx; end
        else begin m_phase = P_DRAIN; m_drained = 0; end
      end
      P_DRAIN: if (done_cell) begin
        m_drained++;
        if (m_drained == LANE_DEPTH) m_phase = P_DONE;
      end
      default: if (start) m_phase = P_IDLE;
    endcase
  endtask

  always @(posedge clk) if (rst_n) model_step();

  // ---------------- stimulus state ----------------
  int rom [0:1023];
  bit rom_pend = 1'b0;
  int rom_cnt = 0, rom_addr = 0, lat_cfg = 2;
  int player = 0, pmode = 0, pause_left = 0, rd_seen = 0;
  bit pause_fired = 1'b0, start_req = 1'b0, wrong_pending = 1'b0;

  task automatic compare_outputs();
    logic [LANE_DEPTH-1:0] er, eb;
    for (int k = 0; k < LANE_DEPTH; k++) begin
      er[k] = (m_cells[k] & 1) != 0;
      eb[k] = (m_cells[k] & 2) != 0;
    end
    check("note_r", nr0, er);
    check("note_b", nb0, eb);
    check("offset", off0, m_ticks / (m_period + 1));
    check("judge_r", jr0, er[HIT_POS]);
    check("judge_b", jb0, eb[HIT_POS]);
    check("chart_rd", rd0, m_rd);
    check("chart_addr", addr0, m_addr);
    check("busy", busy0, m_phase == P_FETCH || m_phase == P_RUN || m_phase == P_DRAIN);
    check("finish", fin0, m_phase == P_DONE);
    check("combo", combo0, m_combo[0]);
    check("max_combo", max0, m_max[0]);
    check("miss_cnt", miss0, m_miss);
    check("strict_combo", combo1, m_combo[1]);
    check("strict_max", max1, m_max[1]);
    if (rd0) rd_seen++;
  endtask

  task automatic drive_stim();
    start = start_req; start_req = 1'b0;
    hit_r = 1'b0; hit_b = 1'b0;
    // pause
    if (pmode == 2 && !pause_fired && m_phase == P_RUN && m_ticks == 2) begin
      pause_fired = 1'b1; pause_left = 50;
    end else if (pmode == 1 && pause_left == 0 && $urandom_range(0, 15) == 0) begin
      pause_left = $urandom_range(1, 6);
    end
    pause = (pause_left > 0);
    if (pause_left > 0) pause_left--;
    // chart ROM
    chart_vld = 1'b0;
    chart_data = 2'($urandom);
    if (rom_pend) begin
      rom_cnt--;
      if (rom_cnt == 0) begin chart_vld = 1'b1; chart_data = 2'(rom[rom_addr]); rom_pend = 1'b0; end
    end
    if (rd0) begin
      rom_pend = 1'b1; rom_addr = int'(addr0);
      rom_cnt = (lat_cfg == 0) ? $urandom_range(1, 4) : lat_cfg;
    end
    // player
    case (player)
      1: begin hit_r = jr0; hit_b = jb0; end
      2: if (m_shift_now()) begin hit_r = jr0; hit_b = jb0; end
      3: begin hit_r = ($urandom_range(0, 3) == 0); hit_b = ($urandom_range(0, 3) == 0); end
      4: if (jb0 && !jr0) begin
        if (!wrong_pending) begin hit_r = 1'b1; wrong_pending = 1'b1; end
        else begin hit_b = 1'b1; wrong_pending = 1'b0; end
      end
      default: ;
    endcase
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_outputs();
    drive_stim();
  endtask

  task automatic run_song(input int len, input int period, input int lat,
                          input int who, input int pm, input int budget);
    int n;
    if (m_phase == P_DONE) begin start_req = 1'b1; cycle(); end
    song_len = ADDR_W'(len); tick_period = TICK_W'(period);
    lat_cfg = lat; player = who; pmode = pm; pause_fired = 1'b0; pause_left = 0;
    rd_seen = 0; wrong_pending = 1'b0;
    start_req = 1'b1;
    cycle();
    n = 0;
    while (m_phase != P_DONE && n < budget) begin cycle(); n++; end
    cycle();
    check("song_finish", fin0, 1);
    check("rd_count", rd_seen, len);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cycle();
    check("idle_busy", busy0, 0);
    check("idle_note_r", nr0, 0);

    // base chart {1,2,3,0}, latency 2, no hits
    rom[0] = 1; rom[1] = 2; rom[2] = 3; rom[3] = 0;
    run_song(4, 0, 2, 0, 0, 500);
    check("a_miss", miss0, 3);
    check("a_combo", combo0, 0);

    // same chart, eager player
    run_song(4, 0, 2, 1, 0, 500);
    check("b_combo", combo0, 4);
    check("b_max", max0, 4);
    check("b_miss", miss0, 0);

    // same chart, press exactly on the shifting cycle
    run_song(4, 0, 2, 2, 0, 500);
    check("c_combo", combo0, 4);
    check("c_miss", miss0, 0);

    // blue-only chart, wrong red press before each blue press
    rom[0] = 2; rom[1] = 2; rom[2] = 2;
    run_song(3, 0, 1, 4, 0, 500);
    check("d_lenient_combo", combo0, 3);
    check("d_strict_combo", combo1, 1);
    check("d_strict_max", max1, 1);

    // directed 50-cycle pause with random presses
    for (int i = 0; i < 6; i++) rom[i] = $urandom_range(0, 3);
    run_song(6, 2, 3, 3, 2, 2000);

    // empty song, then acknowledge
    run_song(0, 1, 1, 0, 0, 500);
    start_req = 1'b1;
    cycle();
    cycle();
    check("ack_finish", fin0, 0);
    check("ack_busy", busy0, 0);

    // reset in the middle of a fetch; the late valid must be ignored
    rom[0] = 3;
    song_len = ADDR_W'(5); tick_period = '0; lat_cfg = 4; player = 0; pmode = 0;
    start_req = 1'b1;
    for (int n = 0; n < 10 && !(m_phase == P_FETCH && m_rd); n++) cycle();
    check("pre_reset_rd", rd0, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_rd", rd0, 0);
    check("reset_busy", busy0, 0);
    cycle();
    rst_n = 1'b1;
    repeat (6) cycle();
    check("late_vld_note", nr0 | nb0, 0);

    // randomized songs
    for (int s = 0; s < 4; s++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) rom[i] = $urandom_range(0, 3);
      run_song(len, $urandom_range(0, 3), 0, (s % 2 == 0) ? 1 : 3, 1, 6000);
    end

    // combo saturation
    for (int i = 0; i < 140; i++) rom[i] = 3;
    run_song(140, 0, 1, 1, 0, 5000);
    check("sat_combo", combo0, CMAX);
    check("sat_max", max0, CMAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/note_lane_scroller.md
Name: note_lane_scroller

Overview:
Parametrised successor to the fixed two-colour note shifter for the LED-matrix rhythm game.
- Scrolls a LANE_DEPTH-cell note window with SUBSTEPS pixel sub-offsets per cell.
- Fetches chart codes from an external chart ROM over a request/valid handshake, instead of holding songs as constants.
- Judges red/blue hits synchronously at cell HIT_POS and keeps combo, max-combo and miss statistics.
- Sits between the chart ROM / button debouncers and the LED-matrix renderer.

Parameters:
LANE_DEPTH, 10, visible cells; cell 0 is bottom/oldest, new codes enter at cell LANE_DEPTH-1
SUBSTEPS, 7, pixel sub-offsets per cell step; OFF_W = $clog2(SUBSTEPS)
HIT_POS, 1, judged cell index (0 < HIT_POS < LANE_DEPTH)
ADDR_W, 10, chart address / song length width
TICK_W, 17, sub-step tick counter width
COMBO_W, 8, combo, max_combo and miss_cnt width; all saturate at all-ones
STRICT, 0, 1 = a press on an empty colour at HIT_POS breaks the combo

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  one-cycle pulse (yellow button): start in IDLE, acknowledge in DONE
pause  in  1  level: freezes scrolling and ignores hits
song_len  in  ADDR_W  number of chart codes; sampled on start
tick_period  in  TICK_W  sub-step period minus one; sampled on start
chart_rd  out  1  one-cycle read request
chart_addr  out  ADDR_W  read address, held from chart_rd until chart_vld
chart_data  in  2  code: bit0 red, bit1 blue (0 none, 3 both)
chart_vld  in  1  data valid; latency >= 1 cycle after chart_rd
hit_r, hit_b  in  1  synchronous one-cycle press pulses
note_r, note_b  out  LANE_DEPTH  per-cell colour bitmaps
offset  out  OFF_W  current sub-offset
judge_r, judge_b  out  1  note_r[HIT_POS], note_b[HIT_POS]
combo, max_combo, miss_cnt  out  COMBO_W  statistics
busy  out  1  state not IDLE/DONE
finish  out  1  high while in DONE

Behaviour:
- Reset: state IDLE; window, offset, index, tick counter and all statistics 0; chart_rd=0, chart_addr=0, finish=0, busy=0.
- States:
  - IDLE: start → clear window/stats/index, latch song_len/tick_period → FETCH; if song_len==0 → DRAIN.
  - FETCH: chart_rd=1 for exactly one cycle, chart_addr=index. Wait for chart_vld, then SHIFT code in, index++ → RUN. chart_vld outside FETCH is ignored.
  - RUN: tick counter counts 0..tick_period. At terminal count, tick counter → 0.
    - If offset < SUBSTEPS-1: offset++.
    - Else: offset → 0, then FETCH if index < song_len, otherwise DRAIN.
  - DRAIN: shift in code 0 at each RUN-style cell step. After LANE_DEPTH zero shifts → DONE.
  - DONE: finish=1, statistics held. start → IDLE, keeping the statistics until the next start.
- Shift: cell k ← cell k+1; new code → cell LANE_DEPTH-1; cell 0 is discarded.
- Miss: a shift discarding a cell 0 with any remaining colour bit → miss_cnt++ (saturating) and combo ← 0.
- Hit: hit_r when red bit set at HIT_POS → clear that bit, combo++. Same rule for hit_b on the blue bit.
  - Both presses on a code-3 cell → both bits cleared, combo += 2.
  - A press on an empty colour is ignored when STRICT=0; when STRICT=1, combo ← 0.
- Hit and shift in the same cycle: the hit is judged on the pre-shift cell HIT_POS, and the cleared value moves to HIT_POS-1.
- A miss and a hit in the same cycle: the miss is applied first (combo ← 0), then the hit increment (combo = 1).
- max_combo ← max(max_combo, next combo) every cycle.
- pause:
  - In RUN/DRAIN: tick counter and offset frozen; hits ignored.
  - In FETCH: an outstanding request still completes and shifts.
- start while busy: ignored. Reset mid-fetch: request abandoned; a late chart_vld after reset is ignored because the state is IDLE.
- tick_period==0: one sub-step per cycle.
- note_r/note_b/judge_* are combinational decodes of the window register. No latches; every output is defined for all codes.

Decomposition:
- Package note_pkg:
  - note code constants NOTE_NONE=0, NOTE_R=1, NOTE_B=2, NOTE_RB=3
  - state enum {IDLE, FETCH, RUN, DRAIN, DONE}
  - saturating-increment function
- One sub-module, note_judge: hit/miss evaluation plus combo, max_combo and miss_cnt counters, fed with cell HIT_POS, cell 0, the shift strobe and the hit pulses.
- Window, fetch FSM and timing stay in the top.

Test Plan:
- Reset, then IDLE with no start → all outputs 0. Pulse rst_n low mid-FETCH → chart_rd=0, state IDLE, late chart_vld ignored.
- song_len=4, codes {1,2,3,0}, tick_period=0, ROM latency 2, no hits → exactly 4 chart_rd pulses at addrs 0..3. Code 1 first appears at note_r[9], offset cycles 0..6. Result: miss_cnt=3, combo=0, finish=1 after 10 drain shifts.
- Same chart, press the matching colour(s) whenever judge_r/judge_b is high → combo=4, max_combo=4, miss_cnt=0; judge bits clear on the cycle after the press.
- Hit coincident with a shift on code 2 at HIT_POS → combo++ and cell HIT_POS-1 shows empty. STRICT=1 with a red press on a blue note → combo=0.
- Pause held 50 cycles in RUN → offset and window frozen, hits ignored; scrolling resumes at the same tick count. song_len=0 → DONE without any chart_rd; start in DONE → IDLE.
- Combo driven to 255 with COMBO_W=8 → combo stays 255, max_combo=255.
